fifo_stream_reader: RTL and testbench

//  Read-side drain stage for async_fifo, in the rd_clk domain. Converts the FIFO's

---
 rtl/fifo_stream_reader.sv | 102 ++++++++++
 tb/tb_fifo_stream_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side drain stage for async_fifo: turns the 1-cycle-latency FIFO read port
// into a valid/ready stream through a 2-entry buffer, with frame tagging and a word count.
module fifo_stream_reader #(
    parameter int DATA_LEN  = 16,
    parameter int FRAME_LEN = 64,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 rd_clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 frame_clr,
    input  logic                 fifo_empty,
    input  logic [DATA_LEN-1:0]  fifo_data,
    output logic                 fifo_rd_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_LEN-1:0]  out_data,
    output logic                 out_last,
    output logic [CNT_WIDTH-1:0] word_count
);

    localparam int FP_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FP_W-1:0] LAST_POS = FP_W'(FRAME_LEN - 1);

    logic [DATA_LEN-1:0]  buf_data_q [2];
    logic [DATA_LEN-1:0]  buf_data_d [2];
    logic [1:0]           buf_last_q, buf_last_d;
    logic                 head_q, head_d;
    logic                 tail_q, tail_d;
    logic [1:0]           occ_q, occ_d;
    logic                 inflight_q, inflight_d;
    logic [FP_W-1:0]      frame_pos_q, frame_pos_d;
    logic [CNT_WIDTH-1:0] word_count_q, word_count_d;

    logic            pop;
    logic [2:0]      level;
    logic [FP_W-1:0] pos_eff;

    // Stream handshake: a word transfers on every rd_clk edge where out_valid and
    // out_ready are both high; out_data/out_last hold while valid is high and ready low.
    assign out_valid  = (occ_q != 2'd0);
    assign out_data   = buf_data_q[head_q];
    assign out_last   = buf_last_q[head_q] & out_valid;
    assign word_count = word_count_q;
    assign pop        = out_valid & out_ready;

    // Words owned after this edge (buffered + inflight - popped) must stay below 2
    // before a new read is allowed; reset kills the request combinationally.
    assign level      = {1'b0, occ_q} + {2'b00, inflight_q};
    assign fifo_rd_en = !reset & enable & !fifo_empty & (level < (3'd2 + {2'b00, pop}));

    always_comb begin
        buf_data_d   = buf_data_q;
        buf_last_d   = buf_last_q;
        head_d       = head_q;
        tail_d       = tail_q;
        occ_d        = occ_q;
        word_count_d = word_count_q;
        inflight_d   = fifo_rd_en & !fifo_empty;
        pos_eff      = frame_clr ? '0 : frame_pos_q;
        frame_pos_d  = pos_eff;

        if (inflight_q) begin
            buf_data_d[tail_q] = fifo_data;
            buf_last_d[tail_q] = (pos_eff == LAST_POS);
            tail_d             = ~tail_q;
            frame_pos_d        = (pos_eff == LAST_POS) ? '0 : pos_eff + FP_W'(1);
        end

        if (pop) begin
            head_d       = ~head_q;
            word_count_d = word_count_q + CNT_WIDTH'(1);
        end

        occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_last_q    <= '0;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            occ_q         <= 2'd0;
            inflight_q    <= 1'b0;
            frame_pos_q   <= '0;
            word_count_q  <= '0;
        end else begin
            buf_data_q[0] <= buf_data_d[0];
            buf_data_q[1] <= buf_data_d[1];
            buf_last_q    <= buf_last_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            occ_q         <= occ_d;
            inflight_q    <= inflight_d;
            frame_pos_q   <= frame_pos_d;
            word_count_q  <= word_count_d;
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO feeding the DUT, expected words
// queued at load time and popped by a monitor on each accepted stream word.
module tb_fifo_stream_reader;

    localparam int DW = 16;
    localparam int FL = 4;
    localparam int CW = 32;

    logic          rd_clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          frame_clr = 1'b0;
    logic          out_ready = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [CW-1:0] word_count;

    fifo_stream_reader #(.DATA_LEN(DW), .FRAME_LEN(FL), .CNT_WIDTH(CW)) dut (
        .rd_clk(rd_clk), .reset(reset), .enable(enable), .frame_clr(frame_clr),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .word_count(word_count)
    );

    always #5 rd_clk = ~rd_clk;

    // Behavioural source FIFO with one-cycle read latency
    logic [DW-1:0] mem [0:1023];
    int rd_idx = 0;
    int wr_idx = 0;
    assign fifo_empty = (rd_idx == wr_idx);

    always @(posedge rd_clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= mem[rd_idx[9:0]];
            rd_idx    <= rd_idx + 1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [DW:0] exp_q[$];
    int exp_pos = 0;
    int cyc = 0;
    int pops_seen = 0;
    int first_cyc = 0;
    int last_cyc = 0;

    always @(posedge rd_clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fifo_put(input logic [DW-1:0] d);
        mem[wr_idx[9:0]] = d;
        wr_idx = wr_idx + 1;
    endtask

    task automatic exp_put(input logic [DW-1:0] d, input logic lst);
        exp_q.push_back({lst, d});
    endtask

    // Load words into the FIFO and queue their expected frame tags
    task automatic push_run(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_put(base + DW'(i));
            exp_put(base + DW'(i), exp_pos == FL - 1);
            exp_pos = (exp_pos + 1) % FL;
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge rd_clk);
        check("drain_timeout_words_left", 64'(exp_q.size()), 64'(0));
        @(posedge rd_clk);
        #1;
    endtask

    task automatic pulse_clr();
        @(posedge rd_clk);
        #1 frame_clr = 1'b1;
        @(posedge rd_clk);
        #1 frame_clr = 1'b0;
        exp_pos = 0;
    endtask

    // Monitor: pops and compares on every accepted word, checks hold-while-stalled
    logic        prev_stall = 1'b0;
    logic [DW:0] prev_word = '0;
    logic [DW:0] w;

    always @(negedge rd_clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", 64'({out_valid, out_last, out_data}), 64'({1'b1, prev_word}));
            if (fifo_rd_en)
                check("rd_en_while_empty", 64'(fifo_empty), 64'(0));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h, expected none", {out_last, out_data});
                end else begin
                    w = exp_q.pop_front();
                    check("stream_word", 64'({out_last, out_data}), 64'(w));
                end
                if (pops_seen == 0) first_cyc = cyc;
                last_cyc = cyc;
                pops_seen++;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge rd_clk);
        @(negedge rd_clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_fifo_rd_en", 64'(fifo_rd_en), 64'(0));
        check("rst_word_count", 64'(word_count), 64'(0));
        @(posedge rd_clk);
        #1 reset = 1'b0;

        // T1: ten preloaded words, latency and back-to-back throughput
        out_ready = 1'b1;
        push_run(16'h0000, 10);
        pops_seen = 0;
        @(posedge rd_clk);
        #1 enable = 1'b1;
        #1;
        check("t1_rd_en_same_cycle", 64'(fifo_rd_en), 64'(1));
        check("t1_valid_before_edge", 64'(out_valid), 64'(0));
        @(posedge rd_clk);
        @(negedge rd_clk);
        check("t1_valid_after_1_edge", 64'(out_valid), 64'(0));
        @(posedge rd_clk);
        @(negedge rd_clk);
        check("t1_valid_after_2_edges", 64'(out_valid), 64'(1));
        wait_drain(50);
        check("t1_no_gaps_span", 64'(last_cyc - first_cyc), 64'(9));
        check("t1_word_count", 64'(word_count), 64'(10));
        check("t1_fifo_empty", 64'(fifo_empty), 64'(1));
        check("t1_rd_en_idle", 64'(fifo_rd_en), 64'(0));

        // T2: empty FIFO, enable held
        for (int i = 0; i < 20; i++) begin
            @(negedge rd_clk);
            check("t2_rd_en", 64'(fifo_rd_en), 64'(0));
            check("t2_out_valid", 64'(out_valid), 64'(0));
        end

        // T3: 100 words with out_ready toggling every cycle
        push_run(16'h1000, 100);
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) begin
            @(posedge rd_clk);
            #1 out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        wait_drain(10);
        check("t3_word_count", 64'(word_count), 64'(110));

        // T4: frame tagging, idle frame_clr, and frame_clr on a capture edge
        pulse_clr();
        push_run(16'h2000, 10);
        wait_drain(50);
        pulse_clr();
        push_run(16'h200A, 7);
        wait_drain(50);
        enable = 1'b0;
        fifo_put(16'h2011);
        exp_put(16'h2011, 1'b0);
        exp_pos = 1;
        @(posedge rd_clk);
        #1 enable = 1'b1;
        @(posedge rd_clk);
        #1 enable = 1'b0;
        frame_clr = 1'b1;
        @(posedge rd_clk);
        #1 frame_clr = 1'b0;
        push_run(16'h2012, 3);
        enable = 1'b1;
        wait_drain(50);
        check("t4_word_count", 64'(word_count), 64'(131));

        // T5: 512 words from a full FIFO after a fresh reset
        enable = 1'b0;
        @(posedge rd_clk);
        #1 reset = 1'b1;
        @(posedge rd_clk);
        #1 reset = 1'b0;
        exp_pos = 0;
        push_run(16'h0000, 512);
        enable = 1'b1;
        wait_drain(1000);
        check("t5_word_count", 64'(word_count), 64'(512));

        // T6: reset with a full buffer and a pending read
        out_ready = 1'b0;
        fifo_put(16'h3000);
        fifo_put(16'h3001);
        fifo_put(16'h3002);
        fifo_put(16'h3003);
        fifo_put(16'h3004);
        repeat (4) @(posedge rd_clk);
        #1;
        check("t6_head_before_reset", 64'({out_valid, out_data}), 64'({1'b1, 16'h3000}));
        out_ready = 1'b1;
        #1;
        check("t6_rd_en_on_pop", 64'(fifo_rd_en), 64'(1));
        reset = 1'b1;
        #1;
        check("t6_rd_en_drops", 64'(fifo_rd_en), 64'(0));
        check("t6_valid_drops", 64'(out_valid), 64'(0));
        exp_q.delete();
        exp_pos = 0;
        exp_put(16'h3002, 1'b0);
        exp_put(16'h3003, 1'b0);
        exp_put(16'h3004, 1'b0);
        repeat (2) @(posedge rd_clk);
        #1 reset = 1'b0;
        check("t6_word_count_cleared", 64'(word_count), 64'(0));
        wait_drain(50);
        check("t6_word_count_after", 64'(word_count), 64'(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
